// File: rtl/csam_pkg.sv
// Shared types and sizing helpers for the carry-save multiplier accumulator stage.
package csam_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   localparam int CSAM_PROD_W = 19;

   // Counter width able to hold the value n itself, not just 0..n-1.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/csam_acc_add.sv
// Accumulator adder: acc + zero-extended product with carry out.
// With CSAM_ACC_SAT_EN defined the sum saturates to all-ones on carry.
module csam_acc_add
   import csam_pkg::*;
#(
   parameter int PROD_W = CSAM_PROD_W,
   parameter int ACC_W  = 24
) (
   input  logic [ACC_W-1:0]  i_acc,
   input  logic [PROD_W-1:0] i_prod,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_carry
);

   logic [ACC_W:0] w_wide;

   assign w_wide  = {1'b0, i_acc} + (ACC_W + 1)'(i_prod);
   assign o_carry = w_wide[ACC_W];

`ifdef CSAM_ACC_SAT_EN
   // Once saturated, any further nonzero add carries again, so all-ones sticks.
   assign o_sum = o_carry ? '1 : w_wide[ACC_W-1:0];
`else
   assign o_sum = w_wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/csam_product_accumulator.sv
// Sums NTERMS multiplier products behind a one-deep product register, valid/ready on both sides.
// Optional saturation of the accumulator is enabled by defining CSAM_ACC_SAT_EN.
module csam_product_accumulator
   import csam_pkg::*;
#(
   parameter int PROD_W = CSAM_PROD_W,
   parameter int NTERMS = 4,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              busy
);

   localparam int               CNT_W = cnt_w(NTERMS);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NTERMS);

   acc_state_t        r_state;
   acc_state_t        w_next_state;
   logic [ACC_W-1:0]  r_acc;
   logic [PROD_W-1:0] r_prod_q;
   logic              r_prod_v;
   logic [CNT_W-1:0]  r_accept_cnt;
   logic [CNT_W-1:0]  r_add_cnt;
   logic              r_overflow;

   logic              w_accept;
   logic              w_last_add;
   logic [ACC_W-1:0]  w_sum;
   logic              w_carry;

   csam_acc_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_add (
      .i_acc   (r_acc),
      .i_prod  (r_prod_q),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign in_ready   = (r_state == ACCUM) && (r_accept_cnt < LAST);
   assign w_accept   = in_valid & in_ready;
   assign w_last_add = r_prod_v && ((r_add_cnt + CNT_W'(1)) == LAST);

   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign acc_out   = r_acc;
   assign overflow  = r_overflow;

   // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (start)      w_next_state = ACCUM;
         ACCUM:   if (w_last_add) w_next_state = DONE;
         DONE:    if (out_ready)  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: all state uses <= so every register samples pre-edge values of its peers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc        <= '0;
         r_prod_q     <= '0;
         r_prod_v     <= 1'b0;
         r_accept_cnt <= '0;
         r_add_cnt    <= '0;
         r_overflow   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_prod_v <= 1'b0;
               if (start) begin
                  r_acc        <= '0;
                  r_accept_cnt <= '0;
                  r_add_cnt    <= '0;
                  r_overflow   <= 1'b0;
               end
            end
            ACCUM: begin
               // Capture and add overlap: the register feeds the adder one edge later.
               r_prod_v <= w_accept;
               if (w_accept) begin
                  r_prod_q     <= prod;
                  r_accept_cnt <= r_accept_cnt + CNT_W'(1);
               end
               if (r_prod_v) begin
                  r_acc      <= w_sum;
                  r_add_cnt  <= r_add_cnt + CNT_W'(1);
                  r_overflow <= r_overflow | w_carry;
               end
            end
            default: begin
               r_prod_v <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csam_product_accumulator.sv
// Self-checking bench: a 24-bit and a 20-bit accumulator share stimulus; results vs. an arithmetic model.
module tb_csam_product_accumulator;

   localparam longint A_MOD = 64'd1 << 24;
   localparam longint B_MOD = 64'd1 << 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [18:0] prod;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_overflow, a_busy;
   logic [23:0] a_acc_out;
   logic        b_in_ready, b_out_valid, b_overflow, b_busy;
   logic [19:0] b_acc_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0][18:0] prods;
      int               gap;
      int               hold;
      int               pulse_k;
      logic [23:0]      exp_acc;
      logic             exp_ovf;
   } vec_t;

   vec_t tbl[4];

   always #5 clk = ~clk;

   csam_product_accumulator #(.PROD_W(19), .NTERMS(4), .ACC_W(24)) u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .prod      (prod),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .acc_out   (a_acc_out),
      .overflow  (a_overflow),
      .busy      (a_busy)
   );

   csam_product_accumulator #(.PROD_W(19), .NTERMS(4), .ACC_W(20)) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .prod      (prod),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .acc_out   (b_acc_out),
      .overflow  (b_overflow),
      .busy      (b_busy)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0][18:0] mk(input int a, input int b, input int c, input int d);
      logic [3:0][18:0] r;
      r[0] = 19'(a);
      r[1] = 19'(b);
      r[2] = 19'(c);
      r[3] = 19'(d);
      return r;
   endfunction

   function automatic longint total4(input logic [3:0][18:0] p);
      longint t = 0;
      for (int k = 0; k < 4; k++) t += longint'(p[k]);
      return t;
   endfunction

   // Reference for the narrow accumulator: exact sum, then wrap or clamp on overflow.
   function automatic longint exp_b_acc(input longint t);
      if (t < B_MOD) return t;
`ifdef CSAM_ACC_SAT_EN
      return B_MOD - 1;
`else
      return t % B_MOD;
`endif
   endfunction

   task automatic run_txn(input logic [3:0][18:0] p, input int gap, input int hold, input int pulse_k,
                          input logic [23:0] exp_acc, input logic exp_ovf, input string tag);
      int     cnt;
      longint t;
      t = total4(p);
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_busy_after_start"}, a_busy, 1);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            prod     = 19'($urandom);
            step();
         end
         in_valid = 1'b1;
         prod     = p[k];
         if (k == pulse_k) start = 1'b1;
         cnt = 0;
         while (!a_in_ready && cnt < 10) begin
            step();
            cnt++;
         end
         if (cnt == 10) check({tag, "_in_ready_timeout"}, 0, 1);
         step();
         in_valid = 1'b0;
         start    = 1'b0;
      end
      check({tag, "_in_ready_after_last"}, a_in_ready, 0);
      check({tag, "_out_valid_early"}, a_out_valid, 0);
      cnt = 0;
      while (!a_out_valid && cnt < 10) begin
         step();
         cnt++;
      end
      check({tag, "_out_valid_latency"}, cnt, 1);
      check({tag, "_acc_a"}, a_acc_out, exp_acc);
      check({tag, "_ovf_a"}, a_overflow, exp_ovf);
      check({tag, "_acc_b"}, b_acc_out, exp_b_acc(t));
      check({tag, "_ovf_b"}, b_overflow, t >= B_MOD);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) step();
      if (hold > 0) begin
         check({tag, "_held_valid"}, a_out_valid, 1);
         check({tag, "_held_acc"}, a_acc_out, exp_acc);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_idle_after_take"}, a_busy, 0);
      check({tag, "_valid_after_take"}, a_out_valid, 0);
      check({tag, "_acc_kept"}, a_acc_out, exp_acc);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      prod      = '0;
      out_ready = 1'b0;

      tbl[0] = '{prods: mk(1, 2, 3, 4),                     gap: 0, hold: 0, pulse_k: -1, exp_acc: 24'd10,      exp_ovf: 1'b0};
      tbl[1] = '{prods: mk(521985, 521985, 521985, 521985), gap: 0, hold: 0, pulse_k: -1, exp_acc: 24'd2087940, exp_ovf: 1'b0};
      tbl[2] = '{prods: mk(5, 6, 7, 8),                     gap: 1, hold: 3, pulse_k: -1, exp_acc: 24'd26,      exp_ovf: 1'b0};
      tbl[3] = '{prods: mk(100, 200, 300, 400),             gap: 0, hold: 1, pulse_k: 2,  exp_acc: 24'd1000,    exp_ovf: 1'b0};

      #13;
      check("rst_acc", a_acc_out, 0);
      check("rst_ovf", a_overflow, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready", a_in_ready, 0);
      check("rst_busy", a_busy, 0);
      check("rst_b_acc", b_acc_out, 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         run_txn(tbl[i].prods, tbl[i].gap, tbl[i].hold, tbl[i].pulse_k,
                 tbl[i].exp_acc, tbl[i].exp_ovf, $sformatf("vec%0d", i));
         if (i == 1) begin
`ifdef CSAM_ACC_SAT_EN
            check("ovf20_acc_const", b_acc_out, 20'hFFFFF);
`else
            check("ovf20_acc_const", b_acc_out, 20'd1039364);
`endif
            check("ovf20_flag_const", b_overflow, 1);
         end
      end

      // in_valid while idle must not be captured or acknowledged.
      in_valid = 1'b1;
      prod     = 19'd999;
      step();
      step();
      check("idle_in_ready", a_in_ready, 0);
      check("idle_busy", a_busy, 0);
      check("idle_acc_kept", a_acc_out, 1000);
      in_valid = 1'b0;

      // Reset in the middle of an accumulation.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         prod     = 19'd77;
         step();
      end
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("midrst_acc", a_acc_out, 0);
      check("midrst_ovf", a_overflow, 0);
      check("midrst_out_valid", a_out_valid, 0);
      check("midrst_in_ready", a_in_ready, 0);
      check("midrst_busy", a_busy, 0);
      @(negedge clk);
      reset = 1'b0;
      step();
      run_txn(mk(10, 10, 10, 10), 0, 0, -1, 24'd40, 1'b0, "post_rst");

      // Randomized accumulations against the arithmetic model.
      for (int r = 0; r < 20; r++) begin
         logic [3:0][18:0] p;
         longint           t;
         for (int k = 0; k < 4; k++)
            p[k] = ($urandom % 2) ? 19'($urandom) : 19'($urandom_range(0, 200000));
         t = total4(p);
         run_txn(p, $urandom_range(0, 2), $urandom_range(0, 3), -1,
                 24'(t % A_MOD), t >= A_MOD, $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
